// File: rtl/pmu_ring_freq_meter.sv
// Purpose: counts rising edges of the asynchronous PMU ring oscillator over a programmable window of wb_clk_i cycles.
// Latency: done arrives win_len+1 cycles after the accepted start; ring edges reach the counter SYNC_STAGES cycles late.
// Backpressure: none; start is ignored while busy (including the done cycle), nothing is queued.
module pmu_ring_freq_meter #(
    parameter int CNT_W       = 16,
    parameter int WIN_W       = 16,
    parameter int SYNC_STAGES = 2   // must be at least 2
) (
    input  logic             wb_clk_i,
    input  logic             wb_rstn_i,
    input  logic             ring_in,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic [WIN_W-1:0]       win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
    logic                   sat_q, sat_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   overflow_q, overflow_d;

    logic edge_pls;
    logic cnt_full;

    // Synchronizer and edge-history chain: free-running in every state so the
    // history flop already tracks the ring level when a window opens.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], ring_in};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    assign edge_pls = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign cnt_full = &edge_cnt_q;

    // Next-state and datapath: window countdown, saturating edge count, and
    // result capture on the transition into DONE so count is valid with done.
    always_comb begin
        state_d    = state_q;
        win_cnt_d  = win_cnt_q;
        edge_cnt_d = edge_cnt_q;
        sat_d      = sat_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    win_cnt_d  = win_len;
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                    if (win_len == '0) begin
                        // Empty window: report zero immediately.
                        state_d    = ST_DONE;
                        count_d    = '0;
                        overflow_d = 1'b0;
                    end else begin
                        state_d = ST_MEASURE;
                    end
                end
            end

            ST_MEASURE: begin
                win_cnt_d = win_cnt_q - WIN_W'(1);
                if (edge_pls) begin
                    if (cnt_full) begin
                        sat_d = 1'b1;
                    end else begin
                        edge_cnt_d = edge_cnt_q + CNT_W'(1);
                    end
                end
                if (win_cnt_q == WIN_W'(1)) begin
                    // Last window cycle: include this cycle's edge in the result.
                    state_d    = ST_DONE;
                    count_d    = edge_cnt_d;
                    overflow_d = sat_d;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset; reset aborts any window.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            state_q    <= ST_IDLE;
            sync_q     <= '0;
            hist_q     <= 1'b0;
            win_cnt_q  <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            hist_q     <= hist_d;
            win_cnt_q  <= win_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_pmu_ring_freq_meter.sv
// Purpose: directed self-checking bench for pmu_ring_freq_meter (16-bit and 4-bit counter instances).
// Latency: results compared once per measurement, sampled 1 ns after the clock edge.
// Backpressure: not applicable; every wait on done is bounded.
module tb_pmu_ring_freq_meter;

    logic        clk;
    logic        rstn;
    logic        ring;
    logic        start;
    logic [15:0] win_len;

    logic        busy, done, overflow;
    logic [15:0] count;
    logic        s_busy, s_done, s_overflow;
    logic [3:0]  s_count;

    int n_tests = 0;
    int n_fail  = 0;

    int ring_half = 0;   // 0: ring held at ring_lvl, else toggle every ring_half cycles
    logic ring_lvl = 1'b0;

    pmu_ring_freq_meter #(.CNT_W(16), .WIN_W(16), .SYNC_STAGES(2)) dut (
        .wb_clk_i (clk),
        .wb_rstn_i(rstn),
        .ring_in  (ring),
        .start    (start),
        .win_len  (win_len),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .overflow (overflow)
    );

    pmu_ring_freq_meter #(.CNT_W(4), .WIN_W(16), .SYNC_STAGES(2)) dut_small (
        .wb_clk_i (clk),
        .wb_rstn_i(rstn),
        .ring_in  (ring),
        .start    (start),
        .win_len  (win_len),
        .busy     (s_busy),
        .done     (s_done),
        .count    (s_count),
        .overflow (s_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ring stimulus, changed on the falling edge.
    initial begin
        int ph;
        ph   = 0;
        ring = 1'b0;
        forever begin
            @(negedge clk);
            if (ring_half == 0) begin
                ring = ring_lvl;
                ph   = 0;
            end else begin
                ph = ph + 1;
                if (ph >= ring_half) begin
                    ring = ~ring;
                    ph   = 0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One measurement. lat = edges after the accepting edge until done is seen,
    // bcyc = sampled cycles with busy high, b_after = busy one cycle after done.
    // xtra_at >= 0 pulses a second start (with xtra_len) after that many edges.
    task automatic run(input int len, input int xtra_at, input int xtra_len,
                       output int lat, output int bcyc, output logic b_after);
        int cyc;
        @(negedge clk);
        win_len = 16'(len);
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 0;
        bcyc  = 0;
        while (!done && cyc < 1000) begin
            if (busy) bcyc++;
            if (cyc == xtra_at) begin
                start   = 1'b1;
                win_len = 16'(xtra_len);
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
        end
        if (!done) chk("done_timeout", 32'(done), 32'd1);
        if (busy) bcyc++;
        lat = cyc;
        @(posedge clk);
        #1;
        b_after = busy;
    endtask

    initial begin
        int   lat, bcyc;
        logic b_after;
        logic seen;

        rstn    = 1'b0;
        start   = 1'b0;
        win_len = 16'd0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ovf",   32'(overflow), 32'd0);
        rstn = 1'b1;

        // Ring held low.
        ring_half = 0; ring_lvl = 1'b0;
        repeat (12) @(posedge clk);
        run(50, -1, 0, lat, bcyc, b_after);
        chk("low_lat",   32'(lat), 32'd50);
        chk("low_count", 32'(count), 32'd0);
        chk("low_ovf",   32'(overflow), 32'd0);
        chk("low_busy",  32'(bcyc), 32'd51);

        // Ring held high: no rising edges once settled.
        ring_lvl = 1'b1;
        repeat (12) @(posedge clk);
        run(50, -1, 0, lat, bcyc, b_after);
        chk("high_lat",   32'(lat), 32'd50);
        chk("high_count", 32'(count), 32'd0);

        // Period 2, window 100 -> 50 edges.
        ring_half = 1;
        repeat (12) @(posedge clk);
        run(100, -1, 0, lat, bcyc, b_after);
        chk("p2_lat",    32'(lat), 32'd100);
        chk("p2_count",  32'(count), 32'd50);
        chk("p2_ovf",    32'(overflow), 32'd0);
        chk("p2_busy",   32'(bcyc), 32'd101);
        chk("p2_bafter", 32'(b_after), 32'd0);

        // Window 40 -> 20 edges; 4-bit counter saturates at 15.
        run(40, -1, 0, lat, bcyc, b_after);
        chk("sat_count_wide",  32'(count), 32'd20);
        chk("sat_ovf_wide",    32'(overflow), 32'd0);
        chk("sat_count_small", 32'(s_count), 32'd15);
        chk("sat_ovf_small",   32'(s_overflow), 32'd1);

        // Window 10 -> 5 edges; saturation flag cleared by the new start.
        run(10, -1, 0, lat, bcyc, b_after);
        chk("w10_count_small", 32'(s_count), 32'd5);
        chk("w10_ovf_small",   32'(s_overflow), 32'd0);
        chk("w10_count_wide",  32'(count), 32'd5);

        // Zero-length window; a start held during the done cycle is ignored.
        @(negedge clk);
        win_len = 16'd0;
        start   = 1'b1;
        @(posedge clk);
        #1;
        chk("w0_done",  32'(done), 32'd1);
        chk("w0_busy",  32'(busy), 32'd1);
        chk("w0_count", 32'(count), 32'd0);
        chk("w0_ovf",   32'(overflow), 32'd0);
        win_len = 16'd5;   // start still high through the done cycle
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("w0_start_in_done_ignored", 32'(busy), 32'd0);

        // Period 4, window 20, second start at T+5 with window 3 is ignored.
        ring_half = 2;
        repeat (12) @(posedge clk);
        run(20, 4, 3, lat, bcyc, b_after);
        chk("p4_lat",   32'(lat), 32'd20);
        chk("p4_count", 32'(count), 32'd5);

        // Reset in the middle of a 100-cycle window.
        ring_half = 1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        win_len = 16'd100;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("mrst_busy",  32'(busy), 32'd0);
        chk("mrst_done",  32'(done), 32'd0);
        chk("mrst_count", 32'(count), 32'd0);
        chk("mrst_ovf",   32'(overflow), 32'd0);
        seen = 1'b0;
        repeat (120) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        chk("mrst_no_done", 32'(seen), 32'd0);

        // Fresh measurement after the abort.
        run(100, -1, 0, lat, bcyc, b_after);
        chk("post_lat",   32'(lat), 32'd100);
        chk("post_count", 32'(count), 32'd50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
